// File: rtl/soc_mem_arbiter_pkg.sv
// rtl/soc_mem_arbiter_pkg.sv - shared types for the two-master memory arbiter
package soc_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

   localparam int TMO_W = 16;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin winner select with debug override
module rr_pick2
   import soc_mem_arbiter_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_owner_i,
   input  logic dbg_prio_i,
   output logic gnt_valid_o,
   output logic winner_o
);

   always_comb begin
      winner_o = OWNER_M0;
      if (req0_i && req1_i) begin
         // On a tie the master served last yields, unless the debugger forces M1
         winner_o = dbg_prio_i ? OWNER_M1 : ~last_owner_i;
      end else if (req1_i) begin
         winner_o = OWNER_M1;
      end
   end

   assign gnt_valid_o = req0_i | req1_i;

endmodule

// File: rtl/soc_mem_arbiter.sv
// rtl/soc_mem_arbiter.sv - shares one slave port between core (M0) and debug (M1)
// Optional watchdog on unacknowledged slave cycles: SOC_ARB_TIMEOUT_EN.
module soc_mem_arbiter
   import soc_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   input  logic              dbg_prio_i,
   output logic              s_req_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic              s_ack_i,
   input  logic [DATA_W-1:0] s_rdata_i
);

   state_t              state_q;
   logic                last_owner_q;
   logic                owner_q;
   logic                we_q;
   logic                s_req_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   m0_rdata_q;
   logic [DATA_W-1:0]   m1_rdata_q;
   logic                m0_ack_q;
   logic                m1_ack_q;
   logic                m0_err_q;
   logic                m1_err_q;
   logic                gnt_valid;
   logic                winner;
   logic                tmo;
   logic [DATA_W-1:0]   resp_data;

   rr_pick2 u_pick (
      .req0_i       (m0_req_i),
      .req1_i       (m1_req_i),
      .last_owner_i (last_owner_q),
      .dbg_prio_i   (dbg_prio_i),
      .gnt_valid_o  (gnt_valid),
      .winner_o     (winner)
   );

`ifdef SOC_ARB_TIMEOUT_EN
   logic [TMO_W-1:0] cnt_q;
   logic [TMO_W-1:0] cnt_d;

   assign cnt_d = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
   // A slave ack in the firing cycle wins, so the transfer completes cleanly
   assign tmo   = !s_ack_i && (cnt_d >= TMO_W'(TIMEOUT_CYC));
`else
   assign tmo   = 1'b0;
`endif

   assign resp_data = s_ack_i ? s_rdata_i : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_owner_q <= OWNER_M1;
         owner_q      <= OWNER_M0;
         we_q         <= 1'b0;
         s_req_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt_valid) begin
                  owner_q      <= winner;
                  last_owner_q <= winner;
                  we_q         <= (winner == OWNER_M1) ? m1_we_i    : m0_we_i;
                  addr_q       <= (winner == OWNER_M1) ? m1_addr_i  : m0_addr_i;
                  wdata_q      <= (winner == OWNER_M1) ? m1_wdata_i : m0_wdata_i;
                  s_req_q      <= 1'b1;
                  state_q      <= ST_BUSY;
`ifdef SOC_ARB_TIMEOUT_EN
                  cnt_q        <= '0;
`endif
               end
            end
            ST_BUSY: begin
               if (s_ack_i || tmo) begin
                  s_req_q <= 1'b0;
                  state_q <= ST_RESP;
                  if (owner_q == OWNER_M1) begin
                     m1_ack_q   <= 1'b1;
                     m1_err_q   <= tmo;
                     m1_rdata_q <= resp_data;
                  end else begin
                     m0_ack_q   <= 1'b1;
                     m0_err_q   <= tmo;
                     m0_rdata_q <= resp_data;
                  end
               end else begin
`ifdef SOC_ARB_TIMEOUT_EN
                  cnt_q <= cnt_d;
`endif
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_req_o    = s_req_q;
   assign s_we_o     = we_q;
   assign s_addr_o   = addr_q;
   assign s_wdata_o  = wdata_q;
   assign m0_ack_o   = m0_ack_q;
   assign m1_ack_o   = m1_ack_q;
   assign m0_err_o   = m0_err_q;
   assign m1_err_o   = m1_err_q;
   assign m0_rdata_o = m0_rdata_q;
   assign m1_rdata_o = m1_rdata_q;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb/tb_soc_mem_arbiter.sv - self-checking bench for soc_mem_arbiter
module tb_soc_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i, dbg_prio_i, s_ack_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i;
   logic [DW-1:0] m0_wdata_i, m1_wdata_i, s_rdata_i;
   logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_req_o, s_we_o;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o, s_wdata_o;
   logic [AW-1:0] s_addr_o;

   int            total = 0;
   int            bad   = 0;
   int            last_m;
   logic [DW-1:0] rd_m [2];
   int            lat;
   int            w;

   soc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
      .dbg_prio_i(dbg_prio_i),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
      .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: lone requester wins; a tie goes to M1 under debug
   // priority, otherwise to whichever master was not served last.
   function automatic int pick(input logic r0, input logic r1, input logic dbg, input int last);
      if (r0 && r1) return dbg ? 1 : (1 - last);
      return r1 ? 1 : 0;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
      m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
      dbg_prio_i = 0; s_ack_i = 0; s_rdata_i = '0;
      step();
      step();
      rst = 1'b0;
      last_m  = 1;
      rd_m[0] = '0;
      rd_m[1] = '0;
   endtask

   task automatic wait_sreq(output int cycles);
      cycles = 0;
      while (!s_req_o && cycles < 40) begin
         step();
         cycles++;
      end
      check("s_req_rise", s_req_o, 1);
   endtask

   // One transaction with `waits` slave wait cycles; checks slave side and response.
   task automatic serve(input int waits, input logic [DW-1:0] rd, output int winner, output int l);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      winner = pick(m0_req_i, m1_req_i, dbg_prio_i, last_m);
      ea = (winner == 1) ? m1_addr_i  : m0_addr_i;
      ed = (winner == 1) ? m1_wdata_i : m0_wdata_i;
      ew = (winner == 1) ? m1_we_i    : m0_we_i;
      wait_sreq(l);
      for (int k = 0; k <= waits; k++) begin
         check("s_req_hold", s_req_o, 1);
         check("s_addr", s_addr_o, ea);
         check("s_we", s_we_o, ew);
         check("s_wdata", s_wdata_o, ed);
         check("no_ack_busy", {m0_ack_o, m1_ack_o}, 0);
         if (k < waits) step();
      end
      s_ack_i = 1'b1;
      s_rdata_i = rd;
      step();
      s_ack_i = 1'b0;
      s_rdata_i = $urandom;
      rd_m[winner] = rd;
      last_m = winner;
      check("ack_owner", (winner == 1) ? m1_ack_o : m0_ack_o, 1);
      check("ack_other", (winner == 1) ? m0_ack_o : m1_ack_o, 0);
      check("rdata0", m0_rdata_o, rd_m[0]);
      check("rdata1", m1_rdata_o, rd_m[1]);
      check("err", {m0_err_o, m1_err_o}, 0);
      check("s_req_drop", s_req_o, 0);
   endtask

   initial begin
      do_reset();
      check("rst_outs", {s_req_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
      check("rst_s_addr", s_addr_o, 0);
      check("rst_s_wdata", s_wdata_o, 0);
      check("rst_rdata", {m0_rdata_o, m1_rdata_o}, 0);

      // single master read latency
      m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h1000;
      serve(0, 32'h1234_5678, w, lat);
      check("lat_req", lat, 1);
      m0_req_i = 0;
      step();
      check("idle_after", {s_req_o, m0_ack_o, m1_ack_o}, 0);
      check("rdata_hold", m0_rdata_o, 32'h1234_5678);

      // contention after reset alternates 0,1,0,1
      do_reset();
      m0_req_i = 1; m0_addr_i = 32'h0000_0100; m0_wdata_i = 32'h1111_0000;
      m1_req_i = 1; m1_addr_i = 32'h0000_0200; m1_wdata_i = 32'h2222_0000;
      for (int i = 0; i < 4; i++) serve(0, 32'hA000_0000 + i, w, lat);

      // debug priority: M1 three times, then M0 once priority drops
      do_reset();
      m0_req_i = 1; m0_addr_i = 32'h0000_0300;
      m1_req_i = 1; m1_addr_i = 32'h0000_0400;
      dbg_prio_i = 1;
      for (int i = 0; i < 3; i++) serve(1, 32'hB000_0000 + i, w, lat);
      dbg_prio_i = 0;
      serve(0, 32'hB000_00FF, w, lat);

      // slave wait states on an M1 write
      do_reset();
      m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h2000; m1_wdata_i = 32'hCAFE_F00D;
      serve(5, 32'h0BAD_0BAD, w, lat);
      m1_req_i = 0;

`ifdef SOC_ARB_TIMEOUT_EN
      do_reset();
      m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h3000;
      serve(0, 32'h5555_AAAA, w, lat);
      m0_req_i = 0;
      step();
      m0_req_i = 1;
      wait_sreq(lat);
      for (int k = 0; k < TMO - 1; k++) begin
         check("tmo_busy", s_req_o, 1);
         check("tmo_no_ack", m0_ack_o, 0);
         step();
      end
      check("tmo_busy_last", s_req_o, 1);
      step();
      check("tmo_ack", m0_ack_o, 1);
      check("tmo_err", m0_err_o, 1);
      check("tmo_rdata", m0_rdata_o, 0);
      check("tmo_s_req", s_req_o, 0);
      check("tmo_other", m1_ack_o, 0);
      rd_m[0] = '0;
      last_m = 0;
      m0_req_i = 0;
      step();
      m0_req_i = 1;
      serve(TMO - 1, 32'hA5A5_5A5A, w, lat);
      m0_req_i = 0;
`endif

      // randomized mix against the reference model
      do_reset();
      for (int it = 0; it < 16; it++) begin
         if (!m0_req_i) begin
            m0_req_i = 1'($urandom_range(0, 1));
            m0_we_i = 1'($urandom_range(0, 1));
            m0_addr_i = $urandom; m0_wdata_i = $urandom;
         end
         if (!m1_req_i) begin
            m1_req_i = 1'($urandom_range(0, 1));
            m1_we_i = 1'($urandom_range(0, 1));
            m1_addr_i = $urandom; m1_wdata_i = $urandom;
         end
         if (!m0_req_i && !m1_req_i) m0_req_i = 1;
         dbg_prio_i = 1'($urandom_range(0, 1));
         serve($urandom_range(0, 3), $urandom, w, lat);
         if (w == 1) m1_req_i = 0; else m0_req_i = 0;
      end
      m0_req_i = 0;
      m1_req_i = 0;
      step();
      step();

      // reset in the middle of a transfer
      do_reset();
      m0_req_i = 1; m0_addr_i = 32'h4000; m0_we_i = 1; m0_wdata_i = 32'h7777_7777;
      serve(0, 32'hDEAD_BEEF, w, lat);
      wait_sreq(lat);
      rst = 1'b1;
      step();
      check("mid_rst_outs", {s_req_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
      check("mid_rst_addr", s_addr_o, 0);
      check("mid_rst_wdata", s_wdata_o, 0);
      check("mid_rst_rdata", {m0_rdata_o, m1_rdata_o}, 0);
      rst = 1'b0;
      m0_req_i = 0;
      last_m = 1;
      rd_m[0] = '0;
      rd_m[1] = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("post_rst_no_ack", {m0_ack_o, m1_ack_o, s_req_o}, 0);
      end
      m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h5000;
      serve(2, 32'h1357_9BDF, w, lat);
      m1_req_i = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
